// File: rtl/sdram_dq_path_if.sv
// User/sequencer-side bundle of sdram_dq_path: burst starts, write word stream,
// read word stream and burst status. The DQ/DQM pins stay on the module itself.
interface sdram_dq_path_if #(
  parameter int DATA_W = 16
) ();
  localparam int BE_W = DATA_W / 8;

  logic              wr_start;
  logic              rd_start;
  logic [DATA_W-1:0] wr_data;
  logic [BE_W-1:0]   wr_be;
  logic              wr_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;

  modport master (
    output wr_start, rd_start, wr_data, wr_be,
    input  wr_req, rd_data, rd_valid, busy, done
  );

  modport slave (
    input  wr_start, rd_start, wr_data, wr_be,
    output wr_req, rd_data, rd_valid, busy, done
  );
endinterface

// File: rtl/sdram_dq_path.sv
// SDRAM DQ/DQM data-bus engine: write bursts with byte enables, CAS-delayed read bursts.
// Optional per-direction word counters are built when SDRAM_DQ_STATS_EN is defined.
module sdram_dq_path #(
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8,
  parameter int CAS_LAT   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sdram_dq_path_if.slave        bus,
  output logic [DATA_W/8-1:0]   sdram_dqm,
  inout  wire  [DATA_W-1:0]     sdram_dq
`ifdef SDRAM_DQ_STATS_EN
  ,
  input  logic                  stats_clr,
  output logic [31:0]           wr_word_cnt,
  output logic [31:0]           rd_word_cnt
`endif
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (BURST_LEN > 4) ? 8 : 2;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(CAS_LAT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WRITE   = 3'd1,
    RD_WAIT = 3'd2,
    READ    = 3'd3,
    RD_END  = 3'd4
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              wr_req_s;
  logic [BE_W-1:0]   dqm_next_s;
  logic              done_next_s;
  logic              busy_next_s;

  logic [DATA_W-1:0] dq_out_r;
  logic              dq_oe_r;
  logic [BE_W-1:0]   dqm_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;
  logic              busy_r;
  logic              done_r;

  // State and beat counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state, beat count, write acceptance and the DQM value for the next cycle
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    wr_req_s     = 1'b0;
    dqm_next_s   = {BE_W{1'b1}};
    case (state_r)
      IDLE: begin
        // A simultaneous rd_start is dropped: writes win the tie.
        if (bus.wr_start) begin
          state_next_s = WRITE;
          cnt_next_s   = {CNT_W{1'b0}};
          wr_req_s     = 1'b1;
          dqm_next_s   = ~bus.wr_be;
        end else if (bus.rd_start) begin
          state_next_s = RD_WAIT;
          cnt_next_s   = {CNT_W{1'b0}};
          dqm_next_s   = {BE_W{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      WRITE: begin
        if (cnt_r == LAST_BEAT) begin
          state_next_s = IDLE;
          cnt_next_s   = {CNT_W{1'b0}};
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
          wr_req_s   = 1'b1;
          dqm_next_s = ~bus.wr_be;
        end
      end
      RD_WAIT: begin
        dqm_next_s = {BE_W{1'b0}};
        if (cnt_r == LAST_WAIT) begin
          state_next_s = READ;
          cnt_next_s   = {CNT_W{1'b0}};
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
        end
      end
      READ: begin
        // Masks return to all ones for the turnaround cycle after the last beat.
        if (cnt_r == LAST_BEAT) begin
          state_next_s = RD_END;
          cnt_next_s   = {CNT_W{1'b0}};
        end else begin
          cnt_next_s = cnt_r + CNT_W'(1);
          dqm_next_s = {BE_W{1'b0}};
        end
      end
      RD_END: begin
        state_next_s = IDLE;
        cnt_next_s   = {CNT_W{1'b0}};
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Status decode one cycle ahead so busy/done come straight from flops
  always_comb begin
    busy_next_s = (state_next_s != IDLE);
    done_next_s = 1'b0;
    if (state_next_s == RD_END) begin
      done_next_s = 1'b1;
    end else if ((state_next_s == WRITE) && (cnt_next_s == LAST_BEAT)) begin
      done_next_s = 1'b1;
    end else begin
      done_next_s = 1'b0;
    end
  end

  // Pin-side registers: DQ drive word/enable, DQM, captured read word and status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_out_r   <= {DATA_W{1'b0}};
      dq_oe_r    <= 1'b0;
      dqm_r      <= {BE_W{1'b1}};
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      dq_oe_r    <= wr_req_s;
      dqm_r      <= dqm_next_s;
      busy_r     <= busy_next_s;
      done_r     <= done_next_s;
      rd_valid_r <= (state_r == READ);
      if (wr_req_s) begin
        dq_out_r <= bus.wr_data;
      end
      if (state_r == READ) begin
        rd_data_r <= sdram_dq;
      end
    end
  end

  assign sdram_dq     = dq_oe_r ? dq_out_r : {DATA_W{1'bz}};
  assign sdram_dqm    = dqm_r;
  assign bus.wr_req   = wr_req_s;
  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;

`ifdef SDRAM_DQ_STATS_EN
  logic [31:0] wr_cnt_r;
  logic [31:0] rd_cnt_r;

  // Saturating word counters; a clear overrides a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_r <= 32'd0;
      rd_cnt_r <= 32'd0;
    end else if (stats_clr) begin
      wr_cnt_r <= 32'd0;
      rd_cnt_r <= 32'd0;
    end else begin
      if (wr_req_s && (wr_cnt_r != 32'hFFFF_FFFF)) begin
        wr_cnt_r <= wr_cnt_r + 32'd1;
      end
      if (rd_valid_r && (rd_cnt_r != 32'hFFFF_FFFF)) begin
        rd_cnt_r <= rd_cnt_r + 32'd1;
      end
    end
  end

  assign wr_word_cnt = wr_cnt_r;
  assign rd_word_cnt = rd_cnt_r;
`endif

endmodule

// File: tb/tb_sdram_dq_path.sv
// Scoreboard bench for sdram_dq_path: two instances (BL=8/CL=3 and BL=1/CL=2)
// with a simple SDRAM DQ model; optional SDRAM_DQ_STATS_EN counters checked too.
module tb_sdram_dq_path;

  localparam int DW  = 16;
  localparam int BL1 = 8;
  localparam int CL1 = 3;
  localparam int BL2 = 1;
  localparam int CL2 = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sdram_dq_path_if #(.DATA_W(DW)) if1 ();
  sdram_dq_path_if #(.DATA_W(DW)) if2 ();

  wire  [DW-1:0] dq1;
  wire  [DW-1:0] dq2;
  logic [1:0]    dqm1;
  logic [1:0]    dqm2;
  logic [DW-1:0] mdl_dq1;
  logic [DW-1:0] mdl_dq2;
  logic          mdl_oe1;
  logic          mdl_oe2;

  assign dq1 = mdl_oe1 ? mdl_dq1 : {DW{1'bz}};
  assign dq2 = mdl_oe2 ? mdl_dq2 : {DW{1'bz}};

`ifdef SDRAM_DQ_STATS_EN
  logic        stats_clr;
  logic [31:0] wcnt1, rcnt1, wcnt2, rcnt2;
`endif

  sdram_dq_path #(.DATA_W(DW), .BURST_LEN(BL1), .CAS_LAT(CL1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1), .sdram_dqm(dqm1), .sdram_dq(dq1)
`ifdef SDRAM_DQ_STATS_EN
    , .stats_clr(stats_clr), .wr_word_cnt(wcnt1), .rd_word_cnt(rcnt1)
`endif
  );

  sdram_dq_path #(.DATA_W(DW), .BURST_LEN(BL2), .CAS_LAT(CL2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2), .sdram_dqm(dqm2), .sdram_dq(dq2)
`ifdef SDRAM_DQ_STATS_EN
    , .stats_clr(stats_clr), .wr_word_cnt(wcnt2), .rd_word_cnt(rcnt2)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_inputs(input int s, input logic ws, input logic rs,
                            input logic [DW-1:0] d, input logic [1:0] be);
    if (s == 1) begin
      if1.wr_start = ws; if1.rd_start = rs; if1.wr_data = d; if1.wr_be = be;
    end else begin
      if2.wr_start = ws; if2.rd_start = rs; if2.wr_data = d; if2.wr_be = be;
    end
  endtask

  task automatic set_model(input int s, input logic oe, input logic [DW-1:0] d);
    if (s == 1) begin
      mdl_oe1 = oe; mdl_dq1 = d;
    end else begin
      mdl_oe2 = oe; mdl_dq2 = d;
    end
  endtask

  // Drive enable of the DQ pins is observed through the instance's output-enable flop.
  task automatic sample(input int s, output logic req, output logic vld, output logic bsy,
                        output logic dne, output logic oe, output logic [1:0] dqm,
                        output logic [DW-1:0] dq, output logic [DW-1:0] rdd);
    if (s == 1) begin
      req = if1.wr_req; vld = if1.rd_valid; bsy = if1.busy; dne = if1.done;
      oe = u_dut1.dq_oe_r; dqm = dqm1; dq = dq1; rdd = if1.rd_data;
    end else begin
      req = if2.wr_req; vld = if2.rd_valid; bsy = if2.busy; dne = if2.done;
      oe = u_dut2.dq_oe_r; dqm = dqm2; dq = dq2; rdd = if2.rd_data;
    end
  endtask

  // One burst on instance s; rd_at injects an extra rd_start in that cycle (-1 = none)
  task automatic run_op(input int s, input int bl, input int cl, input bit is_wr,
                        input int rd_at, input int be_idx);
    logic [DW+1:0] wq[$];
    logic [DW-1:0] rq[$];
    logic [DW+1:0] we;
    logic [DW-1:0] re;
    logic req, vld, bsy, dne, oe;
    logic [1:0] dqm, be;
    logic [DW-1:0] dq, rdd, d;
    int last;
    last = is_wr ? bl : (cl + bl + 1);
    for (int t = 0; t <= last + 2; t++) begin
      @(posedge clk); #1;
      be = (t == be_idx) ? 2'b01 : 2'b11;
      d  = 16'h1000 + 16'(t);
      set_inputs(s, is_wr && (t == 0), ((!is_wr) && (t == 0)) || (t == rd_at), d, be);
      if (!is_wr && (t >= cl + 1) && (t <= cl + bl)) begin
        set_model(s, 1'b1, 16'h00A0 + 16'(t - cl - 1));
        rq.push_back(16'h00A0 + 16'(t - cl - 1));
      end else begin
        set_model(s, 1'b0, 16'h0000);
      end
      if (is_wr && (t <= bl - 1)) wq.push_back({d, ~be});
      @(negedge clk);
      sample(s, req, vld, bsy, dne, oe, dqm, dq, rdd);
      check_eq("wr_req", {31'd0, req}, {31'd0, is_wr && (t <= bl - 1)});
      check_eq("busy", {31'd0, bsy}, {31'd0, (t >= 1) && (t <= last)});
      check_eq("done", {31'd0, dne}, {31'd0, t == last});
      check_eq("dq_oe", {31'd0, oe}, {31'd0, is_wr && (t >= 1) && (t <= bl)});
      check_eq("rd_valid", {31'd0, vld}, {31'd0, !is_wr && (t >= cl + 2) && (t <= last)});
      if (is_wr) begin
        if (oe) begin
          if (wq.size() == 0) begin
            check_eq("wr_q_empty", 32'd1, 32'd0);
          end else begin
            we = wq.pop_front();
            check_eq("dq_word", {16'd0, dq}, {16'd0, we[DW+1:2]});
            check_eq("dqm_word", {30'd0, dqm}, {30'd0, we[1:0]});
          end
        end else begin
          check_eq("dqm_idle", {30'd0, dqm}, 32'd3);
        end
      end else begin
        check_eq("dqm_rd", {30'd0, dqm}, ((t >= 1) && (t <= cl + bl)) ? 32'd0 : 32'd3);
        if (vld) begin
          if (rq.size() == 0) begin
            check_eq("rd_q_empty", 32'd1, 32'd0);
          end else begin
            re = rq.pop_front();
            check_eq("rd_data", {16'd0, rdd}, {16'd0, re});
          end
        end
      end
    end
    set_inputs(s, 1'b0, 1'b0, 16'h0000, 2'b11);
    check_eq("wr_q_left", wq.size(), 32'd0);
    check_eq("rd_q_left", rq.size(), 32'd0);
    if (!is_wr) check_eq("rd_hold", {16'd0, rdd}, {16'd0, 16'h00A0 + 16'(bl - 1)});
  endtask

  task automatic check_reset_state(input int s, input string tag);
    logic req, vld, bsy, dne, oe;
    logic [1:0] dqm;
    logic [DW-1:0] dq, rdd;
    sample(s, req, vld, bsy, dne, oe, dqm, dq, rdd);
    check_eq({tag, "_oe"}, {31'd0, oe}, 32'd0);
    check_eq({tag, "_dqm"}, {30'd0, dqm}, 32'd3);
    check_eq({tag, "_rd_valid"}, {31'd0, vld}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, bsy}, 32'd0);
    check_eq({tag, "_done"}, {31'd0, dne}, 32'd0);
    check_eq({tag, "_rd_data"}, {16'd0, rdd}, 32'd0);
    check_eq({tag, "_wr_req"}, {31'd0, req}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_inputs(1, 1'b0, 1'b0, 16'h0000, 2'b11);
    set_inputs(2, 1'b0, 1'b0, 16'h0000, 2'b11);
    set_model(1, 1'b0, 16'h0000);
    set_model(2, 1'b0, 16'h0000);
`ifdef SDRAM_DQ_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state(1, "rst1");
    check_reset_state(2, "rst2");
    rst_n = 1'b1;

    run_op(1, BL1, CL1, 1'b1, -1, 2);   // write burst, word 2 low byte only
    run_op(1, BL1, CL1, 1'b0, -1, -1);  // read burst CL=3
    run_op(2, BL2, CL2, 1'b0, -1, -1);  // read CL=2, BL=1
    run_op(1, BL1, CL1, 1'b1, 0, -1);   // simultaneous starts: write wins
    run_op(1, BL1, CL1, 1'b1, 3, -1);   // rd_start during WRITE is dropped

    // Reset in the middle of a read burst
    for (int t = 0; t <= 6; t++) begin
      @(posedge clk); #1;
      set_inputs(1, 1'b0, t == 0, 16'h0000, 2'b11);
      if ((t >= CL1 + 1) && (t <= 6)) set_model(1, 1'b1, 16'h00A0 + 16'(t - CL1 - 1));
      if (t == 6) begin
        rst_n = 1'b0;
        #1;
        check_reset_state(1, "midrst");
      end
    end
    set_model(1, 1'b0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
`ifdef SDRAM_DQ_STATS_EN
    check_eq("wcnt_rst", wcnt1, 32'd0);
    check_eq("rcnt_rst", rcnt1, 32'd0);
`endif
    run_op(2, BL2, CL2, 1'b1, -1, 0);   // BL=1 write: one word in T1
    run_op(1, BL1, CL1, 1'b1, -1, -1);
    run_op(1, BL1, CL1, 1'b0, -1, -1);

`ifdef SDRAM_DQ_STATS_EN
    check_eq("wr_word_cnt", wcnt1, 32'd8);
    check_eq("rd_word_cnt", rcnt1, 32'd8);
    @(posedge clk); #1;
    stats_clr = 1'b1;
    @(posedge clk); #1;
    stats_clr = 1'b0;
    check_eq("wcnt_clr", wcnt1, 32'd0);
    check_eq("rcnt_clr", rcnt1, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_dq_path.md
Name: sdram_dq_path

Overview:
- Parametrised SDRAM data-bus engine, successor to the fixed 16-bit data block.
- Owns the bidirectional DQ bus and the DQM byte masks for one SDRAM device. Generic width, burst length and CAS latency; adds byte-enable writes and a read-valid strobe.
- Sits between the SDRAM command sequencer, which issues ACT/READ/WRITE and pulses the starts, and the user read/write FIFOs.

Parameters:
- DATA_W, 16, DQ bus width; multiple of 8; 8..64.
- BURST_LEN, 8, words per burst; 1..256.
- CAS_LAT, 3, CAS latency in clocks; 2 or 3.
- Derived (localparam): BE_W = DATA_W/8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- wr_start  in  1  write-burst start pulse; sampled only in IDLE.
- rd_start  in  1  read-burst start pulse; sampled only in IDLE.
- wr_data  in  DATA_W  write word; consumed in every cycle wr_req=1.
- wr_be  in  BE_W  byte enables for wr_data; 1 = write the byte.
- wr_req  out  1  combinational; wr_data/wr_be accepted this cycle.
- rd_data  out  DATA_W  registered read word.
- rd_valid  out  1  rd_data valid this cycle.
- busy  out  1  burst in progress; starts ignored.
- done  out  1  one-cycle pulse in the final busy cycle.
- sdram_dqm  out  BE_W  DQM pins, registered.
- sdram_dq  inout  DATA_W  SDRAM data bus.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State is IDLE.
  - sdram_dq is high-Z.
  - sdram_dqm is all ones.
  - rd_data is 0; rd_valid, busy, done and wr_req are 0.
  - Reset mid-burst releases DQ immediately (asynchronous); the burst is abandoned and no done pulse is produced.
- States: IDLE, WRITE, RD_WAIT, READ, RD_END. 2-bit burst counter, widened to 8 bits for BURST_LEN up to 256. busy = (state != IDLE).
- IDLE:
  - wr_start=1 goes to WRITE. wr_start has priority: if rd_start=1 in the same cycle, it is dropped.
  - Else rd_start=1 goes to RD_WAIT.
  - Starts arriving in any non-IDLE state are dropped, with no queueing.
- Write, wr_start sampled at T0:
  - wr_req=1 in T0..T(BL-1).
  - WRITE occupies T1..T(BL). The DQ output register drives sdram_dq with the word accepted in the previous cycle; output enable is registered and high exactly T1..T(BL).
  - sdram_dqm = ~wr_be of that word, aligned with its data.
  - Sequencer issues the WRITE command in T1.
  - done=1 in T(BL); IDLE at T(BL+1).
  - BL=1: wr_req only in T0, WRITE for T1 only.
- Read, rd_start sampled at T0; sequencer issues READ in T1:
  - RD_WAIT occupies T1..T(CL).
  - READ occupies T(CL+1)..T(CL+BL). sdram_dq is sampled at the end of each of these cycles into rd_data.
  - rd_valid=1 in T(CL+2)..T(CL+BL+1).
  - RD_END is the single cycle T(CL+BL+1): done=1 and rd_valid=1 (last word).
  - sdram_dqm=0 for T1..T(CL+BL); it returns to all ones in RD_END.
  - DQ is never driven during a read. RD_END gives the bus-turnaround cycle, so a write accepted afterwards first drives at T(CL+BL+3).
- Back-to-back operation: a start may be presented in the cycle after done; the earliest accept is the first IDLE cycle.
- Outside WRITE, sdram_dqm is all ones except during a read as above.
- rd_data holds its last value when rd_valid=0.

Optional Feature:
- Macro: SDRAM_DQ_STATS_EN.
- Defined:
  - Adds ports wr_word_cnt out 32 and rd_word_cnt out 32.
  - wr_word_cnt increments on every wr_req cycle; rd_word_cnt increments on every rd_valid cycle.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
  - Adds stats_clr in 1, a synchronous clear; an increment in the same cycle as stats_clr is lost (clear wins).
- Undefined: the three ports and the counters are absent. Behaviour is otherwise identical.

Test Plan:
- Write burst (DATA_W=16, BL=8): wr_start at T0, wr_data=0x1000+i, wr_be=2'b11 -> wr_req T0..T7; DQ driven 0x1000..0x1007 in T1..T8; dqm=00; done at T8; DQ is Z at T9.
- Byte mask: write word 2 with wr_be=2'b01 -> sdram_dqm=2'b10 in T3 only; all other words 00.
- Read (BL=8, CL=3): rd_start at T0; model drives 0xA0+i in T4..T11 -> rd_valid T5..T12 carrying 0xA0..0xA7; done at T12; DQ never driven; CL=2 shifts every cycle one earlier.
- Collisions: wr_start and rd_start together in IDLE -> write runs, read dropped. rd_start during WRITE -> ignored; busy stays 1; no rd_valid.
- Reset mid-read: rst_n low at T6 -> DQ Z, dqm=all ones, rd_valid=0 asynchronously. After release, a new write (BL=1) drives exactly one word in T1.
- SDRAM_DQ_STATS_EN: one BL=8 write plus one BL=8 read -> wr_word_cnt=8, rd_word_cnt=8. stats_clr -> both 0 the next cycle.
